psk8_symbol_packer: RTL and testbench

//  Upstream stage of psk8_mapper. Accepts a byte stream (valid/ready) and repacks it MSB-first into
//  3-bit 8PSK symbols at a fixed symbol rate set by an internal divider.

---
 rtl/psk8_pkg.sv | 18 +
 rtl/symbol_tick_gen.sv | 25 ++
 rtl/psk8_symbol_packer.sv | 115 +++++++++++
 tb/tb_psk8_symbol_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psk8_pkg.sv
// psk8_pkg: symbol width, idle code and packer state encoding shared by the 8PSK datapath
package psk8_pkg;

    localparam int SYM_W = 4;
    localparam logic [SYM_W-1:0] IDLE_SYM = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH
    } packer_state_t;

    // Data symbols carry a clear top bit so the mapper can tell them from IDLE_SYM
    function automatic logic [SYM_W-1:0] data_sym(input logic [2:0] bits);
        return {1'b0, bits};
    endfunction

endpackage

// File: rtl/symbol_tick_gen.sv
// symbol_tick_gen: free-running symbol-rate divider, one tick every SYM_DIV enabled cycles
module symbol_tick_gen #(
    parameter int SYM_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(SYM_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(SYM_DIV - 1));

    // Count only while enabled so a pause resumes at the same symbol phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/psk8_symbol_packer.sv
// psk8_symbol_packer: repacks a valid/ready byte stream MSB-first into 3-bit 8PSK symbols
module psk8_symbol_packer
    import psk8_pkg::*;
#(
    parameter int SYM_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_strobe,
    output logic             underflow,
    output logic             busy
);

    logic             tick;
    logic             accept;
    logic             full_sym;
    logic             tail_sym;
    logic             drain;
    logic [9:0]       acc;
    logic [9:0]       acc_t;
    logic [9:0]       acc_nx;
    logic [3:0]       nb;
    logic [3:0]       nb_t;
    logic [3:0]       nb_nx;
    logic             last_pending;
    logic             last_pending_nx;
    logic             ready_q;
    logic             ready_nx;
    packer_state_t    state;
    packer_state_t    state_nx;
    logic [SYM_W-1:0] sym_nx;
    logic             strobe_nx;
    logic             underflow_nx;

    symbol_tick_gen #(
        .SYM_DIV(SYM_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    // ready_q is registered so byte_ready never depends on byte_valid
    assign byte_ready = en && ready_q;
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state != ST_IDLE);

    // Tick consumes from the pre-accept buffer first, then an accepted byte lands below the survivors
    always_comb begin
        full_sym        = (nb >= 4'd3);
        tail_sym        = last_pending && (nb != 4'd0) && !full_sym;
        drain           = tick && (full_sym || tail_sym);
        acc_t           = !drain ? acc : (full_sym ? {acc[6:0], 3'b000} : 10'd0);
        nb_t            = !drain ? nb : (full_sym ? nb - 4'd3 : 4'd0);
        acc_nx          = accept ? (acc_t | ({byte_data, 2'b00} >> nb_t)) : acc_t;
        nb_nx           = accept ? nb_t + 4'd8 : nb_t;
        last_pending_nx = accept ? byte_last : ((drain && nb_t == 4'd0) ? 1'b0 : last_pending);
        ready_nx        = (nb_nx <= 4'd2) && !last_pending_nx;
    end

    // Frame tracking: a last byte moves to FLUSH, and FLUSH ends on the tick that empties the buffer
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = !accept ? ST_IDLE : (byte_last ? ST_FLUSH : ST_ACTIVE);
            ST_ACTIVE: state_nx = (accept && byte_last) ? ST_FLUSH : ST_ACTIVE;
            ST_FLUSH:  state_nx = (drain && nb_t == 4'd0) ? ST_IDLE : ST_FLUSH;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Symbol selection: left-aligned buffer means a padded tail is just the top three bits
    always_comb begin
        strobe_nx    = tick;
        sym_nx       = !tick ? sym_out : (drain ? data_sym(acc[9:7]) : IDLE_SYM);
        underflow_nx = tick && !drain && (state == ST_ACTIVE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Buffer, ready flag and registered symbol outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            nb           <= '0;
            last_pending <= 1'b0;
            ready_q      <= 1'b0;
            sym_out      <= IDLE_SYM;
            sym_strobe   <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            acc          <= acc_nx;
            nb           <= nb_nx;
            last_pending <= last_pending_nx;
            ready_q      <= ready_nx;
            sym_out      <= sym_nx;
            sym_strobe   <= strobe_nx;
            underflow    <= underflow_nx;
        end
    end

endmodule

// File: tb/tb_psk8_symbol_packer.sv
// tb_psk8_symbol_packer: directed frames with a symbol scoreboard checked by a separate monitor
module tb_psk8_symbol_packer;
    import psk8_pkg::*;

    localparam int SYM_DIV = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_last = 1'b0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic [SYM_W-1:0] sym_out;
    logic             sym_strobe;
    logic             underflow;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    int idle_cnt = 0;
    int uf_cnt = 0;
    int acc_cnt = 0;
    int gap = 0;
    logic busy_at_pop = 1'b1;
    logic [SYM_W-1:0] prev_sym = IDLE_SYM;

    psk8_symbol_packer #(.SYM_DIV(SYM_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .byte_data (byte_data),
        .byte_last (byte_last),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .sym_out   (sym_out),
        .sym_strobe(sym_strobe),
        .underflow (underflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on every data strobe and checks timing/hold properties
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            gap = 0;
            prev_sym = IDLE_SYM;
        end else begin
            if (sym_strobe) begin
                chk("strobe_spacing", gap, SYM_DIV);
                gap = 0;
                if (sym_out != IDLE_SYM) begin
                    chk("underflow_on_data", {31'd0, underflow}, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sym: got %0h required no data symbol", sym_out);
                    end else begin
                        logic [2:0] e;
                        e = exp_q.pop_front();
                        chk("sym_out", {28'd0, sym_out}, {28'd0, data_sym(e)});
                    end
                    busy_at_pop = busy;
                end else begin
                    idle_cnt++;
                    if (underflow) uf_cnt++;
                end
            end else begin
                chk("sym_hold", {28'd0, sym_out}, {28'd0, prev_sym});
                chk("underflow_without_strobe", {31'd0, underflow}, 0);
            end
            prev_sym = sym_out;
            if (byte_valid && byte_ready) acc_cnt++;
            if (en) gap++;
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        byte_data  = d;
        byte_last  = last;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h never accepted, required acceptance", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] s[]);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic wait_q(input string nm, input int left);
        int n = 0;
        while (exp_q.size() > left && n < 600) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(nm, exp_q.size(), left);
    endtask

    task automatic settle(input int cyc);
        repeat (cyc) @(posedge clk);
        #2;
    endtask

    initial begin
        int uf0, idle0, acc0, n;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int uf0, idle0, acc0, n, uf1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sym_out", {28'd0, sym_out}, {28'd0, IDLE_SYM});
        chk("rst_strobe", {31'd0, sym_strobe}, 0);
        chk("rst_underflow", {31'd0, underflow}, 0);
        chk("rst_ready", {31'd0, byte_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle(2);

        // 1: three-byte frame, valid held high
        uf0 = uf_cnt; acc0 = acc_cnt;
        push('{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
        send(8'h05, 1'b0); send(8'h39, 1'b0); send(8'h77, 1'b1);
        byte_valid = 1'b0;
        wait_q("t1_drain", 0);
        chk("t1_busy_fell_with_last", {31'd0, busy_at_pop}, 0);
        settle(12);
        chk("t1_no_underflow", uf_cnt - uf0, 0);
        chk("t1_accepts", acc_cnt - acc0, 3);
        chk("t1_idle_busy", {31'd0, busy}, 0);

        // 2: single byte frame with padded tail
        uf0 = uf_cnt;
        push('{3'd5, 3'd1, 3'd2});
        send(8'hA5, 1'b1);
        byte_valid = 1'b0;
        wait_q("t2_drain", 0);
        chk("t2_busy_fell", {31'd0, busy_at_pop}, 0);
        settle(16);
        chk("t2_no_underflow", uf_cnt - uf0, 0);

        // 3: starvation mid-frame, then a last byte completes it
        push('{3'd7, 3'd7});
        send(8'hFF, 1'b0);
        byte_valid = 1'b0;
        wait_q("t3_first_drain", 0);
        idle0 = idle_cnt; uf0 = uf_cnt; n = 0;
        while (idle_cnt - idle0 < 3 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t3_starved_ticks", idle_cnt - idle0, 3);
        chk("t3_underflow_each", uf_cnt - uf0, 3);
        chk("t3_still_active", {31'd0, busy}, 1);
        push('{3'd6, 3'd0, 3'd0, 3'd0});
        send(8'h00, 1'b1);
        byte_valid = 1'b0;
        wait_q("t3_drain", 0);
        chk("t3_uf_matches_idle", uf_cnt - uf0, idle_cnt - idle0);
        chk("t3_busy_fell", {31'd0, busy_at_pop}, 0);
        uf1 = uf_cnt;
        settle(12);
        chk("t3_idle_no_underflow", uf_cnt, uf1);

        // 4: six-byte frame under back-pressure
        acc0 = acc_cnt; uf0 = uf_cnt;
        push('{3'd0, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd6,
               3'd3, 3'd6, 3'd1, 3'd1, 3'd5, 3'd2, 3'd7, 3'd4});
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0);
        send(8'h78, 1'b0); send(8'h9A, 1'b0); send(8'hBC, 1'b1);
        byte_valid = 1'b0;
        wait_q("t4_drain", 0);
        settle(12);
        chk("t4_accepts", acc_cnt - acc0, 6);
        chk("t4_no_underflow", uf_cnt - uf0, 0);

        // 5: enable pause mid-frame
        push('{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
        fork
            begin
                send(8'h05, 1'b0); send(8'h39, 1'b0); send(8'h77, 1'b1);
                byte_valid = 1'b0;
            end
            begin
                wait_q("t5_before_pause", 5);
                en = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("t5_pause_ready", {31'd0, byte_ready}, 0);
                    chk("t5_pause_strobe", {31'd0, sym_strobe}, 0);
                    @(posedge clk);
                end
                #1 en = 1'b1;
            end
        join
        wait_q("t5_drain", 0);
        settle(12);

        // 6: asynchronous reset mid-frame, then a fresh frame
        push('{3'd7, 3'd7});
        send(8'hFF, 1'b0);
        byte_valid = 1'b0;
        wait_q("t6_two_syms", 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sym_out", {28'd0, sym_out}, {28'd0, IDLE_SYM});
        chk("t6_rst_strobe", {31'd0, sym_strobe}, 0);
        chk("t6_rst_underflow", {31'd0, underflow}, 0);
        chk("t6_rst_ready", {31'd0, byte_ready}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push('{3'd0, 3'd1, 3'd2});
        send(8'h05, 1'b1);
        byte_valid = 1'b0;
        wait_q("t6_drain", 0);
        settle(12);
        chk("t6_final_busy", {31'd0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
